// File: rtl/calc_entry_ctrl.sv
// -----------------------------------------------------------------------------
// calc_entry_ctrl
// Keypad entry controller for a two-operand, two-digit calculator. Each
// fresh key press (rising edge of key_valid) is accepted once, acknowledged
// with a one-cycle key_ack pulse, and steers the entry FSM
// ENTER1 -> OPER -> ENTER2 -> RESULT.
//
// Ports
//   clk         in   system clock, rising edge active
//   reset       in   asynchronous active-high reset
//   key_valid   in   key-present level from the keypad scanner
//   key_code    in   [4:0] key identity (0-9 digits, 16 ENTER, 17 CLEAR,
//                    20..24 add/sub/mul/div/mod)
//   tens_mem_1  out  [4:0] operand-1 tens digit (0-9, 11 = blank)
//   ones_mem_1  out  [4:0] operand-1 ones digit
//   tens_mem_2  out  [4:0] operand-2 tens digit (0-9, 11 = blank)
//   ones_mem_2  out  [4:0] operand-2 ones digit
//   num_state   out  [2:0] entry phase
//   arithmetic  out  [4:0] one-hot operator (00000 = none)
//   key_ack     out  one-cycle pulse per accepted key
// -----------------------------------------------------------------------------
module calc_entry_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [4:0] tens_mem_1,
    output logic [4:0] ones_mem_1,
    output logic [4:0] tens_mem_2,
    output logic [4:0] ones_mem_2,
    output logic [2:0] num_state,
    output logic [4:0] arithmetic,
    output logic       key_ack
);

    localparam logic [2:0] S_ENTER1 = 3'b000;
    localparam logic [2:0] S_OPER   = 3'b001;
    localparam logic [2:0] S_ENTER2 = 3'b010;
    localparam logic [2:0] S_RESULT = 3'b011;

    localparam logic [4:0] K_ENTER  = 5'd16;
    localparam logic [4:0] K_CLEAR  = 5'd17;
    localparam logic [4:0] BLANK    = 5'd11;

    // Operator key code to one-hot; zero for anything that is not an operator.
    function automatic logic [4:0] oper_onehot(input logic [4:0] code);
        logic [4:0] oh;
        case (code)
            5'd20:   oh = 5'b00001;
            5'd21:   oh = 5'b00010;
            5'd22:   oh = 5'b00100;
            5'd23:   oh = 5'b01000;
            5'd24:   oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    logic [2:0] state_q, state_d;
    logic [4:0] arith_q, arith_d;
    logic [4:0] tens1_q, tens1_d, ones1_q, ones1_d;
    logic [4:0] tens2_q, tens2_d, ones2_q, ones2_d;
    logic [1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic       kv_q, kv_d;
    logic       ack_q, ack_d;

    logic       accept_s;
    logic       is_digit_s;
    logic [4:0] oper_s;

    assign accept_s   = key_valid & ~kv_q;
    assign is_digit_s = (key_code <= 5'd9);
    assign oper_s     = oper_onehot(key_code);

    // Next-state logic for the entry FSM and operand registers.
    always_comb begin
        state_d = state_q;
        arith_d = arith_q;
        tens1_d = tens1_q;
        ones1_d = ones1_q;
        tens2_d = tens2_q;
        ones2_d = ones2_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        kv_d    = key_valid;
        ack_d   = accept_s;

        if (state_q[2]) begin
            // Unreachable encoding: fall back to the reset contents.
            state_d = S_ENTER1;
            arith_d = 5'b00000;
            tens1_d = BLANK;
            ones1_d = 5'd0;
            tens2_d = BLANK;
            ones2_d = 5'd0;
            cnt1_d  = 2'd0;
            cnt2_d  = 2'd0;
        end else if (accept_s && (key_code == K_CLEAR)) begin
            state_d = S_ENTER1;
            arith_d = 5'b00000;
            tens1_d = BLANK;
            ones1_d = 5'd0;
            tens2_d = BLANK;
            ones2_d = 5'd0;
            cnt1_d  = 2'd0;
            cnt2_d  = 2'd0;
        end else if (accept_s) begin
            case (state_q)
                S_ENTER1: begin
                    if (is_digit_s) begin
                        // A third digit is dropped; the counter saturates at 2.
                        if (cnt1_q == 2'd0) begin
                            ones1_d = key_code;
                            cnt1_d  = 2'd1;
                        end else if (cnt1_q == 2'd1) begin
                            tens1_d = ones1_q;
                            ones1_d = key_code;
                            cnt1_d  = 2'd2;
                        end else begin
                            cnt1_d  = cnt1_q;
                        end
                    end else if ((oper_s != 5'b00000) && (cnt1_q != 2'd0)) begin
                        arith_d = oper_s;
                        state_d = S_OPER;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_OPER: begin
                    if (oper_s != 5'b00000) begin
                        arith_d = oper_s;
                    end else if (is_digit_s) begin
                        tens2_d = BLANK;
                        ones2_d = key_code;
                        cnt2_d  = 2'd1;
                        state_d = S_ENTER2;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ENTER2: begin
                    if (is_digit_s) begin
                        if (cnt2_q == 2'd0) begin
                            ones2_d = key_code;
                            cnt2_d  = 2'd1;
                        end else if (cnt2_q == 2'd1) begin
                            tens2_d = ones2_q;
                            ones2_d = key_code;
                            cnt2_d  = 2'd2;
                        end else begin
                            cnt2_d  = cnt2_q;
                        end
                    end else if (key_code == K_ENTER) begin
                        state_d = S_RESULT;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RESULT: begin
                    if (is_digit_s) begin
                        // Digit starts a fresh calculation as operand 1.
                        state_d = S_ENTER1;
                        arith_d = 5'b00000;
                        tens1_d = BLANK;
                        ones1_d = key_code;
                        tens2_d = BLANK;
                        ones2_d = 5'd0;
                        cnt1_d  = 2'd1;
                        cnt2_d  = 2'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = S_ENTER1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers; key_valid copy resets high so a held key is not taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_ENTER1;
            arith_q <= 5'b00000;
            tens1_q <= BLANK;
            ones1_q <= 5'd0;
            tens2_q <= BLANK;
            ones2_q <= 5'd0;
            cnt1_q  <= 2'd0;
            cnt2_q  <= 2'd0;
            kv_q    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arith_q <= arith_d;
            tens1_q <= tens1_d;
            ones1_q <= ones1_d;
            tens2_q <= tens2_d;
            ones2_q <= ones2_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            kv_q    <= kv_d;
            ack_q   <= ack_d;
        end
    end

    assign tens_mem_1 = tens1_q;
    assign ones_mem_1 = ones1_q;
    assign tens_mem_2 = tens2_q;
    assign ones_mem_2 = ones2_q;
    assign num_state  = state_q;
    assign arithmetic = arith_q;
    assign key_ack    = ack_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [4:0] key_code;
    logic [4:0] tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2;
    logic [2:0] num_state;
    logic [4:0] arithmetic;
    logic       key_ack;

    calc_entry_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .tens_mem_1 (tens_mem_1),
        .ones_mem_1 (ones_mem_1),
        .tens_mem_2 (tens_mem_2),
        .ones_mem_2 (ones_mem_2),
        .num_state  (num_state),
        .arithmetic (arithmetic),
        .key_ack    (key_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] t1, o1, t2, o2;
        logic [2:0] st;
        logic [4:0] ar;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acks_seen = 0;
    int   acks_want = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, ".tens1"}, {27'd0, tens_mem_1}, {27'd0, e.t1});
        chk({tag, ".ones1"}, {27'd0, ones_mem_1}, {27'd0, e.o1});
        chk({tag, ".tens2"}, {27'd0, tens_mem_2}, {27'd0, e.t2});
        chk({tag, ".ones2"}, {27'd0, ones_mem_2}, {27'd0, e.o2});
        chk({tag, ".state"}, {29'd0, num_state},  {29'd0, e.st});
        chk({tag, ".arith"}, {27'd0, arithmetic}, {27'd0, e.ar});
    endtask

    // Monitor: every key_ack pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && key_ack) begin
            acks_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got key_ack=1 expected no pulse");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk_outs(e.tag, e);
            end
        end
    end

    // Press one key: queue the expected register contents, hold, release.
    task automatic press(input logic [4:0] code, input int hold, input string tag,
                         input logic [4:0] t1, input logic [4:0] o1,
                         input logic [4:0] t2, input logic [4:0] o2,
                         input logic [2:0] st, input logic [4:0] ar);
        exp_t e;
        e.t1 = t1; e.o1 = o1; e.t2 = t2; e.o2 = o2; e.st = st; e.ar = ar; e.tag = tag;
        exp_q.push_back(e);
        acks_want++;
        key_valid = 1'b1;
        key_code  = code;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    exp_t rst_e;

    initial begin
        rst_e.t1 = 5'd11; rst_e.o1 = 5'd0; rst_e.t2 = 5'd11; rst_e.o2 = 5'd0;
        rst_e.st = 3'd0;  rst_e.ar = 5'd0; rst_e.tag = "reset";

        // Reset with a key already held across release.
        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = 5'd5;
        repeat (3) @(negedge clk);
        chk_outs("reset", rst_e);
        chk("reset.ack", {31'd0, key_ack}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_at_release.ones1", {27'd0, ones_mem_1}, 32'd0);
        key_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Basic calculation 42 + 7 ENTER.
        press(5'd4,  1, "k4",    5'd11, 5'd4, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd2,  1, "k2",    5'd4,  5'd2, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd20, 1, "kadd",  5'd4,  5'd2, 5'd11, 5'd0, 3'd1, 5'b00001);
        press(5'd7,  1, "k7",    5'd4,  5'd2, 5'd11, 5'd7, 3'd2, 5'b00001);
        press(5'd16, 1, "kent",  5'd4,  5'd2, 5'd11, 5'd7, 3'd3, 5'b00001);
        // Operator in RESULT ignored, digit restarts, then a second digit.
        press(5'd21, 1, "res_op", 5'd4, 5'd2, 5'd11, 5'd7, 3'd3, 5'b00001);
        press(5'd6,  2, "res_6",  5'd11, 5'd6, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd3,  1, "res_3",  5'd6,  5'd3, 5'd11, 5'd0, 3'd0, 5'b00000);

        // Saturation at two digits.
        press(5'd17, 1, "clr1",  5'd11, 5'd0, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd1,  1, "sat1",  5'd11, 5'd1, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd2,  1, "sat2",  5'd1,  5'd2, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd3,  1, "sat3",  5'd1,  5'd2, 5'd11, 5'd0, 3'd0, 5'b00000);

        // Held key accepted once; count becomes 1 so the next digit shifts.
        press(5'd17, 1, "clr2",  5'd11, 5'd0, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd5, 20, "hold5", 5'd11, 5'd5, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd8,  1, "hold8", 5'd5,  5'd8, 5'd11, 5'd0, 3'd0, 5'b00000);

        // Operator with empty operand ignored, then replacement in OPER.
        press(5'd17, 1, "clr3",  5'd11, 5'd0, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd20, 1, "op_e",  5'd11, 5'd0, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd16, 1, "ent_e1",5'd11, 5'd0, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd9,  1, "k9",    5'd11, 5'd9, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd21, 1, "ksub",  5'd11, 5'd9, 5'd11, 5'd0, 3'd1, 5'b00010);
        press(5'd22, 1, "kmul",  5'd11, 5'd9, 5'd11, 5'd0, 3'd1, 5'b00100);
        press(5'd16, 1, "ent_op",5'd11, 5'd9, 5'd11, 5'd0, 3'd1, 5'b00100);
        press(5'd31, 1, "illeg", 5'd11, 5'd9, 5'd11, 5'd0, 3'd1, 5'b00100);
        press(5'd8,  1, "e2_8",  5'd11, 5'd9, 5'd11, 5'd8, 3'd2, 5'b00100);
        press(5'd1,  1, "e2_1",  5'd11, 5'd9, 5'd8,  5'd1, 3'd2, 5'b00100);
        press(5'd3,  1, "e2_3",  5'd11, 5'd9, 5'd8,  5'd1, 3'd2, 5'b00100);
        press(5'd24, 1, "e2_op", 5'd11, 5'd9, 5'd8,  5'd1, 3'd2, 5'b00100);

        // Asynchronous reset between edges in ENTER2.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_outs("async_rst", rst_e);
        chk("async_rst.ack", {31'd0, key_ack}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // CLEAR in OPER.
        press(5'd5,  1, "c5",    5'd11, 5'd5, 5'd11, 5'd0, 3'd0, 5'b00000);
        press(5'd23, 1, "cdiv",  5'd11, 5'd5, 5'd11, 5'd0, 3'd1, 5'b01000);
        press(5'd17, 1, "clr_op",5'd11, 5'd0, 5'd11, 5'd0, 3'd0, 5'b00000);

        repeat (5) @(negedge clk);
        chk("ack_count", acks_seen, acks_want);
        chk("pending_exp", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

Interface
REQ-001: clk  input  1  system clock; all state changes on rising edge.
REQ-002: reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-003: key_valid  input  1  key-present level from the keypad scanner; held high while a key is down.
REQ-004: key_code  input  5  key identity, valid while key_valid=1: 0-9 digits; 16 ENTER; 17 CLEAR; 20 add, 21 sub, 22 mul, 23 div, 24 mod; all other codes illegal.
REQ-005: tens_mem_1, ones_mem_1  output  5 each  operand-1 tens and ones digit codes (0-9, or 11 = blank).
REQ-006: tens_mem_2, ones_mem_2  output  5 each  operand-2 tens and ones digit codes (0-9, or 11 = blank).
REQ-007: num_state  output  3  entry phase: 000 ENTER1, 001 OPER, 010 ENTER2, 011 RESULT.
REQ-008: arithmetic  output  5  one-hot operator: 00001 add, 00010 sub, 00100 mul, 01000 div, 10000 mod, 00000 none.
REQ-009: key_ack  output  1  one-cycle pulse per accepted key.

Function
REQ-010: A key SHALL be accepted only on a cycle where key_valid=1 and the registered copy of key_valid from the previous cycle is 0; a held key SHALL be accepted exactly once.
REQ-011: All register updates for an accepted key SHALL occur on the accepting clock edge; key_ack SHALL be high for exactly the one cycle after that edge.
REQ-012: Illegal key codes, and legal keys not valid in the current state, SHALL be ignored with no register change, but key_ack SHALL still pulse.
REQ-013: Each operand SHALL have a 2-bit digit counter (0, 1, 2) that saturates at 2.
REQ-014: Digit entry SHALL work as follows:
- count 0: ones<=digit, tens stays 11.
- count 1: tens<=ones, ones<=digit.
- count 2: digit ignored.
REQ-015: ENTER1 (000) SHALL handle keys as follows:
- Digits update operand 1.
- An operator key with count1>=1 loads arithmetic and moves to OPER.
- An operator key with count1=0 is ignored.
- ENTER is ignored.
REQ-016: OPER (001) SHALL handle keys as follows:
- An operator key replaces arithmetic and stays in OPER.
- A digit clears operand 2, writes the digit as operand-2's first digit, and moves to ENTER2.
- ENTER is ignored.
REQ-017: ENTER2 (010) SHALL handle keys as follows:
- Digits update operand 2.
- ENTER moves to RESULT.
- Operator keys are ignored.
REQ-018: RESULT (011) SHALL handle keys as follows:
- A digit clears both operands and arithmetic, writes the digit as operand-1's first digit, and moves to ENTER1.
- All other keys except CLEAR are ignored.
REQ-019: CLEAR SHALL restore the reset values of every register in any state.
REQ-020: num_state value 1xx SHALL never be produced; any unreachable encoding SHALL recover to ENTER1 with reset values on the next clock.
REQ-021: Operand-1 registers SHALL not change outside ENTER1, except on CLEAR and the RESULT-to-ENTER1 digit restart.

Reset
REQ-022: On reset the outputs SHALL be:
- num_state=000, arithmetic=00000.
- tens_mem_1=tens_mem_2=11, ones_mem_1=ones_mem_2=0.
- key_ack=0, digit counters=0.
- Registered key_valid copy=1, so a key already held at reset release is not accepted.
REQ-023: A reset asserted mid-entry SHALL discard all partial operands and operator without waiting for a clock edge.

Verification
REQ-024: Reset released, then keys 4, 2, add(20), 7, ENTER -> tens_mem_1=4, ones_mem_1=2, arithmetic=00001, tens_mem_2=11, ones_mem_2=7, num_state=011; five key_ack pulses.
REQ-025: In ENTER1, keys 1, 2, 3 -> tens_mem_1=1, ones_mem_1=2; digit 3 ignored; key_ack pulses 3 times.
REQ-026: key_valid held high 20 cycles with code 5 -> ones_mem_1=5 once, one key_ack pulse, count1=1.
REQ-027: In ENTER1 with count1=0, add -> num_state stays 000; then 9, sub(21), mul(22) -> arithmetic=00100, num_state=001.
REQ-028: In RESULT, digit 6 -> num_state=000, ones_mem_1=6, tens_mem_1=11, operand 2 blank/0, arithmetic=00000.
REQ-029: In ENTER2 after 3 digits, assert reset asynchronously between edges -> all outputs at reset values before the next rising edge; CLEAR in OPER -> same values one edge later.
